// File: rtl/lfsr_test_sequencer.sv
// lfsr_test_sequencer
//   Runs one LFSR loopback test over a shared APB bus: enables the sink,
//   programs the source frame length, starts the source, polls the sink
//   status until its done bit rises (or a polling timeout expires), reads
//   the sink error counter and reports pass/fail.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start              one-cycle launch pulse, ignored while busy
//   abort              level request to stop the running test
//   length             frame length, captured at start
//   err_threshold      largest error count that still passes, captured at start
//   m_p*               APB master: shared addr/write/wdata/enable, one select per
//                      slave, per-slave rdata/ready/slverr
//   busy, done, pass   run status; pass is valid from done until the next start
//   err_count          sink error counter read back
//   timeout, apb_err   polling timed out / a slave reported pslverr
module lfsr_test_sequencer #(
  parameter int AddrBits      = 5,
  parameter int SrcCtrlAddr   = 0,
  parameter int SrcLenAddr    = 4,
  parameter int SnkCtrlAddr   = 0,
  parameter int SnkStatAddr   = 4,
  parameter int SnkErrAddr    = 8,
  parameter int PollInterval  = 16,
  parameter int TimeoutCycles = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         length,
  input  logic [31:0]         err_threshold,
  output logic [AddrBits-1:0] m_paddr,
  output logic                m_pwrite,
  output logic [31:0]         m_pwdata,
  output logic                m_penable,
  output logic                m_psel_src,
  output logic                m_psel_snk,
  input  logic [31:0]         m_prdata_src,
  input  logic [31:0]         m_prdata_snk,
  input  logic                m_pready_src,
  input  logic                m_pready_snk,
  input  logic                m_pslverr_src,
  input  logic                m_pslverr_snk,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         err_count,
  output logic                timeout,
  output logic                apb_err
);

  typedef enum logic [2:0] {
    IDLE, SNK_EN, SRC_LEN, SRC_GO, POLL_WAIT, POLL_RD, ERR_RD, FINISH
  } state_t;

  // Everything the bus needs to describe one transfer.
  typedef struct packed {
    logic                sel_src;
    logic                sel_snk;
    logic [AddrBits-1:0] addr;
    logic                write;
    logic [31:0]         wdata;
  } xfer_t;

  localparam logic [AddrBits-1:0] SRC_CTRL  = AddrBits'(SrcCtrlAddr);
  localparam logic [AddrBits-1:0] SRC_LEN_A = AddrBits'(SrcLenAddr);
  localparam logic [AddrBits-1:0] SNK_CTRL  = AddrBits'(SnkCtrlAddr);
  localparam logic [AddrBits-1:0] SNK_STAT  = AddrBits'(SnkStatAddr);
  localparam logic [AddrBits-1:0] SNK_ERR   = AddrBits'(SnkErrAddr);
  localparam logic [31:0]         POLL_LAST = 32'(PollInterval - 1);
  localparam logic [31:0]         TMO_LAST  = 32'(TimeoutCycles - 1);

  // Transfer issued on entry to a bus state; non-bus states select nothing.
  function automatic xfer_t xfer_for(input state_t s, input logic [15:0] len);
    xfer_t x;
    // NOTE: x starts at '0 so every field has a value on every path.
    x = '0;
    case (s)
      SNK_EN:  begin x.sel_snk = 1'b1; x.addr = SNK_CTRL;  x.write = 1'b1; x.wdata = 32'h1; end
      SRC_LEN: begin x.sel_src = 1'b1; x.addr = SRC_LEN_A; x.write = 1'b1; x.wdata = {16'b0, len}; end
      SRC_GO:  begin x.sel_src = 1'b1; x.addr = SRC_CTRL;  x.write = 1'b1; x.wdata = 32'h1; end
      POLL_RD: begin x.sel_snk = 1'b1; x.addr = SNK_STAT; end
      ERR_RD:  begin x.sel_snk = 1'b1; x.addr = SNK_ERR; end
      default: x = '0;
    endcase
    return x;
  endfunction

  state_t      state;
  xfer_t       apb;
  logic        penable_q;
  logic [15:0] length_q;
  logic [31:0] thr_q;
  logic [31:0] poll_cnt;
  logic [31:0] tmo_cnt;
  logic        aborted;

  // Response path follows the active select; the idle slave is never looked at.
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;
  logic        xfer_done;
  logic        in_poll;
  logic        tmo_expired;
  logic        stop_req;

  assign sel_ready   = apb.sel_src ? m_pready_src  : m_pready_snk;
  assign sel_err     = apb.sel_src ? m_pslverr_src : m_pslverr_snk;
  assign sel_rdata   = apb.sel_src ? m_prdata_src  : m_prdata_snk;
  assign xfer_done   = penable_q && sel_ready;
  assign in_poll     = (state == POLL_WAIT) || (state == POLL_RD);
  assign tmo_expired = (tmo_cnt >= TMO_LAST);
  assign stop_req    = abort || aborted;

  assign m_paddr    = apb.addr;
  assign m_pwrite   = apb.write;
  assign m_pwdata   = apb.wdata;
  assign m_psel_src = apb.sel_src;
  assign m_psel_snk = apb.sel_snk;
  assign m_penable  = penable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      apb       <= '0;
      penable_q <= 1'b0;
      length_q  <= '0;
      thr_q     <= '0;
      poll_cnt  <= '0;
      tmo_cnt   <= '0;
      aborted   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      timeout   <= 1'b0;
      apb_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values;
      // a later assignment in this block overrides an earlier default.
      done <= 1'b0;
      if (busy && abort) aborted <= 1'b1;

      // SETUP always lasts exactly one cycle before ACCESS.
      if ((apb.sel_src || apb.sel_snk) && !penable_q) penable_q <= 1'b1;

      // Timeout budget covers only the polling loop; it saturates at the limit.
      if (in_poll) begin
        if (!tmo_expired) tmo_cnt <= tmo_cnt + 32'd1;
        else              timeout <= 1'b1;
      end

      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped.
          if (start && !done) begin
            state     <= SNK_EN;
            apb       <= xfer_for(SNK_EN, length);
            penable_q <= 1'b0;
            length_q  <= length;
            thr_q     <= err_threshold;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            timeout   <= 1'b0;
            apb_err   <= 1'b0;
            aborted   <= 1'b0;
            poll_cnt  <= '0;
            tmo_cnt   <= '0;
          end
        end

        POLL_WAIT: begin
          if (stop_req) begin
            state <= FINISH;
          end else if (tmo_expired || timeout) begin
            timeout <= 1'b1;
            state   <= ERR_RD;
            apb     <= xfer_for(ERR_RD, length_q);
          end else if (poll_cnt == POLL_LAST) begin
            state <= POLL_RD;
            apb   <= xfer_for(POLL_RD, length_q);
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end

        FINISH: begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count <= thr_q) && !timeout && !apb_err && !aborted;
        end

        default: begin
          // Bus states: hold the transfer until the selected slave is ready.
          if (xfer_done) begin
            penable_q   <= 1'b0;
            apb.sel_src <= 1'b0;
            apb.sel_snk <= 1'b0;
            if (sel_err) begin
              apb_err <= 1'b1;
              state   <= FINISH;
            end else if (stop_req) begin
              state <= FINISH;
            end else begin
              case (state)
                SNK_EN:  begin state <= SRC_LEN; apb <= xfer_for(SRC_LEN, length_q); end
                SRC_LEN: begin state <= SRC_GO;  apb <= xfer_for(SRC_GO, length_q); end
                SRC_GO: begin
                  state    <= POLL_WAIT;
                  poll_cnt <= '0;
                  tmo_cnt  <= '0;
                end
                POLL_RD: begin
                  if (timeout || tmo_expired || sel_rdata[0]) begin
                    if (timeout || tmo_expired) timeout <= 1'b1;
                    state <= ERR_RD;
                    apb   <= xfer_for(ERR_RD, length_q);
                  end else begin
                    state    <= POLL_WAIT;
                    poll_cnt <= '0;
                  end
                end
                ERR_RD: begin
                  err_count <= sel_rdata;
                  state     <= FINISH;
                end
                default: state <= FINISH;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_test_sequencer.sv
// tb_lfsr_test_sequencer
//   Directed bench: behavioural source/sink APB slaves with configurable wait
//   states, slave error, status-ready poll number and error register; a bus
//   monitor logs completed transfers as {snk, write, addr, wdata[15:0]}.
module tb_lfsr_test_sequencer;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   length = '0;
  logic [31:0]   err_threshold = '0;
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [31:0]   m_pwdata;
  logic          m_penable;
  logic          m_psel_src;
  logic          m_psel_snk;
  logic [31:0]   m_prdata_src = '0;
  logic [31:0]   m_prdata_snk = '0;
  logic          m_pready_src = 1'b0;
  logic          m_pready_snk = 1'b0;
  logic          m_pslverr_src = 1'b0;
  logic          m_pslverr_snk = 1'b0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [31:0]   err_count;
  logic          timeout;
  logic          apb_err;

  always #5 clk = ~clk;

  lfsr_test_sequencer #(
    .AddrBits(AW), .PollInterval(4), .TimeoutCycles(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .length(length), .err_threshold(err_threshold),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
    .m_penable(m_penable), .m_psel_src(m_psel_src), .m_psel_snk(m_psel_snk),
    .m_prdata_src(m_prdata_src), .m_prdata_snk(m_prdata_snk),
    .m_pready_src(m_pready_src), .m_pready_snk(m_pready_snk),
    .m_pslverr_src(m_pslverr_src), .m_pslverr_snk(m_pslverr_snk),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .timeout(timeout), .apb_err(apb_err)
  );

  int total = 0;
  int bad   = 0;

  // Slave configuration, written only by the stimulus block.
  int          test_id = 0;
  int          wait_states = 0;
  int          ready_on = 0;      // status bit0 rises on this poll (0 = never)
  logic [31:0] err_reg = '0;
  bit          err_on_src_len = 1'b0;

  // Monitor state, written only by the slave block; cleared on a new test_id.
  int          seen_id = 0;
  int          acc_cnt = 0;
  int          status_reads = 0;
  int          done_cnt = 0;
  int          stab_bad = 0;
  int          both_sel = 0;
  int          idle_run = 0;
  int          last_gap = 0;
  logic [31:0] log_q[$];
  logic [AW-1:0] s_addr = '0;
  logic        s_wr = 1'b0;
  logic [31:0] s_wdata = '0;

  // Slaves respond on the falling edge; the unselected slave drives junk.
  always @(negedge clk) begin : slaves
    logic [31:0] rd;
    logic        err;
    logic        rdy;
    if (test_id != seen_id) begin
      seen_id = test_id;
      log_q.delete();
      status_reads = 0; done_cnt = 0; stab_bad = 0; both_sel = 0;
      idle_run = 0; last_gap = 0; acc_cnt = 0;
    end
    rd = 32'h0; err = 1'b0; rdy = 1'b0;
    if (m_psel_src && m_psel_snk) both_sel++;
    if (m_psel_src || m_psel_snk) begin
      if (!m_penable) begin
        s_addr = m_paddr; s_wr = m_pwrite; s_wdata = m_pwdata; acc_cnt = 0;
        rdy = 1'b1;  // ready during SETUP must not complete the transfer
      end else begin
        if (m_paddr !== s_addr || m_pwrite !== s_wr || m_pwdata !== s_wdata) stab_bad++;
        if (acc_cnt < wait_states) begin
          acc_cnt++;
        end else begin
          rdy = 1'b1;
          if (m_psel_snk && !m_pwrite && m_paddr == 5'd4) begin
            status_reads++;
            rd = 32'hFFFF_FFFE | {31'd0, (ready_on != 0 && status_reads >= ready_on)};
          end else if (m_psel_snk && !m_pwrite && m_paddr == 5'd8) begin
            rd = err_reg;
          end
          err = err_on_src_len && m_psel_src && m_pwrite && m_paddr == 5'd4;
          log_q.push_back({4'(m_psel_snk), 4'(m_pwrite), 8'(m_paddr),
                           m_pwrite ? m_pwdata[15:0] : 16'h0});
        end
      end
    end
    m_pready_src  = m_psel_src ? rdy : 1'b1;
    m_pslverr_src = m_psel_src ? err : 1'b1;
    m_prdata_src  = m_psel_src ? rd  : 32'hDEAD_BEEF;
    m_pready_snk  = m_psel_snk ? rdy : 1'b1;
    m_pslverr_snk = m_psel_snk ? err : 1'b1;
    m_prdata_snk  = m_psel_snk ? rd  : 32'hDEAD_BEEF;
    if (m_psel_src || m_psel_snk) begin
      if (idle_run > 0) last_gap = idle_run;
      idle_run = 0;
    end else if (busy) begin
      idle_run++;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_bits();
    return {23'd0, m_psel_src, m_psel_snk, m_penable, m_pwrite,
            busy, done, pass, timeout, apb_err};
  endfunction

  task automatic new_test(input int ws, input int ron, input logic [31:0] er, input bit se);
    wait_states = ws; ready_on = ron; err_reg = er; err_on_src_len = se;
    test_id++;
    tick();
  endtask

  task automatic wait_done(input int max_cycles, input bit mid_start, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = mid_start && (i == 6);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic launch(input int max_cycles, input bit mid_start, output bit got);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(max_cycles, mid_start, got);
  endtask

  initial begin
    bit got;
    bit found;

    // Reset values
    repeat (3) tick();
    check("rst_ctl", ctl_bits(), 32'h0);
    check("rst_paddr", 32'(m_paddr), 32'h0);
    check("rst_pwdata", m_pwdata, 32'h0);
    check("rst_err_count", err_count, 32'h0);
    rst = 1'b0;
    tick();

    // Nominal run, with a stray start while busy and one coincident with done
    new_test(0, 3, 32'h0, 1'b0);
    length = 16'd64; err_threshold = 32'd0;
    launch(400, 1'b1, got);
    check("nom_done_seen", 32'(got), 32'h1);
    check("nom_pass", 32'(pass), 32'h1);
    check("nom_err_count", err_count, 32'h0);
    check("nom_timeout", 32'(timeout), 32'h0);
    check("nom_apb_err", 32'(apb_err), 32'h0);
    check("nom_busy_at_done", 32'(busy), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_start_at_done_ignored", 32'(busy), 32'h0);
    repeat (4) tick();
    check("nom_still_idle", 32'(busy), 32'h0);
    check("nom_xfer_count", 32'(log_q.size()), 32'd7);
    check("nom_x0_snk_en", log_q[0], 32'h1100_0001);
    check("nom_x1_src_len", log_q[1], 32'h0104_0040);
    check("nom_x2_src_go", log_q[2], 32'h0100_0001);
    check("nom_x3_poll", log_q[3], 32'h1004_0000);
    check("nom_x4_poll", log_q[4], 32'h1004_0000);
    check("nom_x5_poll", log_q[5], 32'h1004_0000);
    check("nom_x6_err_rd", log_q[6], 32'h1008_0000);
    check("nom_poll_gap", 32'(last_gap), 32'd4);
    check("nom_done_once", 32'(done_cnt), 32'd1);
    check("nom_one_psel", 32'(both_sel), 32'd0);
    check("nom_stable", 32'(stab_bad), 32'd0);

    // Threshold boundary: 8 errors fail at 7, pass at 8
    new_test(0, 1, 32'd8, 1'b0);
    length = 16'd16; err_threshold = 32'd7;
    launch(400, 1'b0, got);
    check("thr7_done_seen", 32'(got), 32'h1);
    check("thr7_pass", 32'(pass), 32'h0);
    check("thr7_err_count", err_count, 32'd8);
    new_test(0, 1, 32'd8, 1'b0);
    err_threshold = 32'd8;
    launch(400, 1'b0, got);
    check("thr8_done_seen", 32'(got), 32'h1);
    check("thr8_pass", 32'(pass), 32'h1);
    check("thr8_err_count", err_count, 32'd8);

    // Polling timeout: status never ready
    new_test(0, 0, 32'h0, 1'b0);
    err_threshold = 32'd0;
    launch(600, 1'b0, got);
    check("tmo_done_seen", 32'(got), 32'h1);
    check("tmo_timeout", 32'(timeout), 32'h1);
    check("tmo_pass", 32'(pass), 32'h0);
    repeat (4) tick();
    check("tmo_last_is_err_rd", log_q[log_q.size() - 1], 32'h1008_0000);
    check("tmo_done_once", 32'(done_cnt), 32'd1);

    // Three wait states on every transfer
    new_test(3, 3, 32'h0, 1'b0);
    length = 16'd64;
    launch(600, 1'b0, got);
    check("ws_done_seen", 32'(got), 32'h1);
    check("ws_pass", 32'(pass), 32'h1);
    repeat (2) tick();
    check("ws_xfer_count", 32'(log_q.size()), 32'd7);
    check("ws_x1_src_len", log_q[1], 32'h0104_0040);
    check("ws_x6_err_rd", log_q[6], 32'h1008_0000);
    check("ws_stable", 32'(stab_bad), 32'd0);

    // Slave error on the length write stops the sequence
    new_test(0, 3, 32'h0, 1'b1);
    launch(400, 1'b0, got);
    check("slverr_done_seen", 32'(got), 32'h1);
    check("slverr_apb_err", 32'(apb_err), 32'h1);
    check("slverr_pass", 32'(pass), 32'h0);
    repeat (4) tick();
    check("slverr_xfer_count", 32'(log_q.size()), 32'd2);

    // Abort during the length-write access
    new_test(0, 3, 32'h0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_psel_src && m_penable && m_paddr == 5'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("abort_access_seen", 32'(found), 32'h1);
    abort = 1'b1;
    wait_done(100, 1'b0, got);
    check("abort_done_seen", 32'(got), 32'h1);
    check("abort_pass", 32'(pass), 32'h0);
    check("abort_apb_err", 32'(apb_err), 32'h0);
    repeat (3) tick();
    check("abort_idle_no_effect", 32'(busy), 32'h0);
    abort = 1'b0;
    check("abort_xfer_count", 32'(log_q.size()), 32'd2);
    check("abort_x1_completed", log_q[1], 32'h0104_0040);

    // Reset during a status read
    new_test(0, 3, 32'h0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_psel_snk && !m_penable && m_paddr == 5'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rstmid_poll_seen", 32'(found), 32'h1);
    rst = 1'b1;
    tick();
    check("rstmid_ctl", ctl_bits(), 32'h0);
    check("rstmid_paddr", 32'(m_paddr), 32'h0);
    check("rstmid_pwdata", m_pwdata, 32'h0);
    check("rstmid_err_count", err_count, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_no_done", 32'(done_cnt), 32'd0);

    // Clean run after the reset
    new_test(0, 1, 32'h0, 1'b0);
    launch(400, 1'b0, got);
    check("after_rst_done_seen", 32'(got), 32'h1);
    check("after_rst_pass", 32'(pass), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_test_sequencer.md
LFSR_TEST_SEQUENCER -- requirements
Module: lfsr_test_sequencer

Interface
REQ-001 SHALL have parameter AddrBits, default 5, width of the APB address.
REQ-002 SHALL have parameters SrcCtrlAddr=0, SrcLenAddr=4, SnkCtrlAddr=0, SnkStatAddr=4, SnkErrAddr=8, giving the register offsets used.
REQ-003 SHALL have parameter PollInterval, default 16, giving the idle cycles between status polls (minimum 1).
REQ-004 SHALL have parameter TimeoutCycles, default 65535, giving the maximum number of cycles spent in polling.
REQ-005 Ports (name, direction, width, meaning):
  clk  in  1  clock; all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  start  in  1  one-cycle pulse that launches a test; ignored while busy
  abort  in  1  level-sampled request to stop the test
  length  in  16  frame length written to the source; captured at start
  err_threshold  in  32  maximum error count that still passes; captured at start
  m_paddr  out  AddrBits  shared APB address
  m_pwrite  out  1  shared APB write flag
  m_pwdata  out  32  shared APB write data
  m_penable  out  1  shared APB enable
  m_psel_src  out  1  APB select, source
  m_psel_snk  out  1  APB select, sink
  m_prdata_src / m_prdata_snk  in  32  read data
  m_pready_src / m_pready_snk  in  1  ready
  m_pslverr_src / m_pslverr_snk  in  1  slave error
  busy  out  1  high from the cycle after start until done
  done  out  1  one-cycle completion pulse
  pass  out  1  result, valid from done until the next start
  err_count  out  32  sink error count read back
  timeout  out  1  polling timed out
  apb_err  out  1  a pslverr was seen during the test

Function
REQ-006 APB master SHALL emit each transfer as one SETUP cycle (psel=1, penable=0) followed by ACCESS cycles (psel=1, penable=1) until the selected pready=1; addr/write/wdata SHALL stay stable throughout.
REQ-007 Only one psel SHALL be high at a time; prdata/pready/pslverr SHALL be muxed from the selected slave; unselected inputs SHALL be ignored.
REQ-008 State machine states: IDLE, SNK_EN, SRC_LEN, SRC_GO, POLL_WAIT, POLL_RD, ERR_RD, FINISH.
REQ-009 IDLE→SNK_EN on start=1; the cycle start is sampled, length and err_threshold SHALL be captured, and err_count, timeout, apb_err, and pass SHALL be cleared.
REQ-010 SNK_EN SHALL write 32'h1 to SnkCtrlAddr on the sink, then go to SRC_LEN.
REQ-011 SRC_LEN SHALL write {16'b0,length} to SrcLenAddr on the source, then go to SRC_GO.
REQ-012 SRC_GO SHALL write 32'h1 to SrcCtrlAddr on the source, then go to POLL_WAIT.
REQ-013 POLL_WAIT SHALL count PollInterval idle cycles (no psel), then go to POLL_RD.
REQ-014 POLL_RD SHALL read SnkStatAddr. If rdata[0]=1 → ERR_RD; else → POLL_WAIT.
REQ-015 A timeout counter SHALL run while in POLL_WAIT or POLL_RD. On reaching TimeoutCycles, the controller SHALL set timeout=1 and go to ERR_RD once any in-flight transfer completes.
REQ-016 ERR_RD SHALL read SnkErrAddr, latch rdata into err_count, then go to FINISH.
REQ-017 FINISH SHALL pulse done for one cycle, return to IDLE, and drive busy=0 in that same cycle.
REQ-018 pass SHALL equal (err_count <= err_threshold) && !timeout && !apb_err && !aborted.
REQ-019 pslverr=1 on a completing transfer SHALL set apb_err (sticky), and the sequence SHALL jump to FINISH without the remaining transfers.
REQ-020 abort=1: an in-flight APB transfer SHALL complete normally, then the sequence SHALL go to FINISH with pass=0; abort in IDLE SHALL have no effect.
REQ-021 A slave holding pready=0 SHALL stall the sequencer indefinitely outside POLL; the timeout applies only in POLL states.
REQ-022 start while busy SHALL be ignored, including start coincident with done.

Reset
REQ-023 rst SHALL force IDLE and clear all counters.
REQ-024 Output reset values: psel_src, psel_snk, penable, pwrite, busy, done, pass, timeout, apb_err = 0; paddr, pwdata, err_count = 0.
REQ-025 rst asserted mid-transfer SHALL drop psel/penable in the next cycle with no completion pulse.

Verification
REQ-026 Nominal: length=64, threshold=0, both slaves pready=1, sink status bit0=1 on the 3rd poll, err reg=0 → exact write sequence (snk@0=1, src@4=64, src@0=1), 3 status reads, 1 err read, done with pass=1, err_count=0.
REQ-027 Threshold: err reg=8, threshold=7 → pass=0; rerun with threshold=8 → pass=1.
REQ-028 Timeout: TimeoutCycles=100, status bit0 never set → timeout=1, err read still performed, pass=0, done exactly once.
REQ-029 Wait states and slave error: pready low for 3 cycles on each transfer → signals stable, sequence still correct; pslverr on the SRC_LEN write → apb_err=1, no SRC_GO write, done, pass=0.
REQ-030 Abort and reset: abort during the SRC_LEN access → that transfer completes, no further transfers, pass=0; rst during POLL_RD → all outputs at reset values next cycle; start during busy → ignored.
